// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity codes,
// transmitter FSM states and frame-parameter helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_t;

  // Clocks per bit; CLK_FRE is in MHz.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned baud_rate);
    return (clk_fre * 32'd1000000) / baud_rate;
  endfunction

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    if (bits < 4'd5) return 4'd5;
    if (bits > 4'd8) return 4'd8;
    return bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; shared by the UART TX and RX paths.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which
  // entries are valid, and a resettable array cannot map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, parity, 1/2 stop bits,
// break) fed from a small FIFO; frames leave back-to-back while data is queued.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 27,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_data_valid,
  output logic                         tx_data_ready,
  input  logic [3:0]                   cfg_data_bits,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop2,
  input  logic                         tx_break,
  output logic                         tx_pin,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned CYCLE    = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [31:0] BIT_LAST = 32'(CYCLE - 1);

  tx_state_t   state;
  logic [31:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_data;
  logic [3:0]  frm_bits;
  logic        frm_par_en;
  logic        frm_par_bit;
  logic        frm_stop2;
  logic        brk_release;

  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  logic        bit_end;
  logic        last_data;
  logic        last_stop;
  logic        frame_end;
  logic        line_next;
  logic [3:0]  nbits_cfg;
  logic [7:0]  data_mask;
  logic [7:0]  masked;

  assign tx_data_ready = !fifo_full;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_data_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_end   = (baud_cnt == BIT_LAST);
  assign last_data = ({1'b0, bit_cnt} == frm_bits - 4'd1);
  assign last_stop = !frm_stop2 || bit_cnt[0];
  assign frame_end = (state == ST_STOP) && bit_end && last_stop;
  assign fifo_pop  = !fifo_empty && !tx_break && ((state == ST_IDLE) || frame_end);

  // Bits above the configured width are dropped so they never reach parity.
  assign nbits_cfg = clamp_data_bits(cfg_data_bits);
  assign data_mask = ~(8'hFF << nbits_cfg);
  assign masked    = fifo_rdata & data_mask;

  // NOTE: default assigned first so every path drives line_next; no latch.
  always_comb begin
    line_next = 1'b1;
    case (state)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = shift_data[bit_cnt];
      ST_PARITY: line_next = frm_par_bit;
      ST_BREAK:  line_next = brk_release;
      default:   line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_data  <= '0;
      frm_bits    <= 4'd8;
      frm_par_en  <= 1'b0;
      frm_par_bit <= 1'b0;
      frm_stop2   <= 1'b0;
      brk_release <= 1'b0;
      tx_pin      <= 1'b1;
      tx_busy     <= 1'b0;
    end else begin
      tx_pin  <= line_next;
      tx_busy <= (state != ST_IDLE);
      // NOTE: non-blocking throughout; the later assignments in the case
      // below override this default because the last NBA to a signal wins.
      baud_cnt <= bit_end ? '0 : baud_cnt + 32'd1;

      if (fifo_pop) begin
        shift_data  <= masked;
        frm_bits    <= nbits_cfg;
        frm_par_en  <= (cfg_parity == PAR_ODD) || (cfg_parity == PAR_EVEN);
        frm_par_bit <= (cfg_parity == PAR_ODD) ? ~^masked : ^masked;
        frm_stop2   <= cfg_stop2;
      end

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (tx_break) begin
            state       <= ST_BREAK;
            brk_release <= 1'b0;
          end else if (!fifo_empty) begin
            state <= ST_START;
          end
        end
        ST_START: if (bit_end) state <= ST_DATA;
        ST_DATA: begin
          if (bit_end) begin
            if (last_data) begin
              bit_cnt <= '0;
              state   <= frm_par_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: if (bit_end) state <= ST_STOP;
        ST_STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              bit_cnt <= '0;
              if (tx_break) begin
                state       <= ST_BREAK;
                brk_release <= 1'b0;
              end else if (!fifo_empty) begin
                state <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_BREAK: begin
          // Hold low while requested, then one full bit time of mark.
          if (!brk_release) begin
            baud_cnt <= '0;
            if (!tx_break) brk_release <= 1'b1;
          end else if (bit_end) begin
            brk_release <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at CYCLE=4: frame formats, back-to-back burst,
// break handling and asynchronous reset mid-frame.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx_break;
  logic       tx_pin;
  logic       tx_busy;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_cfg #(
    .CLK_FRE    (1),
    .BAUD_RATE  (250000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_break      (tx_break),
    .tx_pin        (tx_pin),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, output int waited);
    waited = 0;
    @(negedge clk);
    tx_data       = d;
    tx_data_valid = 1'b1;
    while (!tx_data_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("push_timeout", 32'(tx_data_ready), 32'd1);
    @(posedge clk);
    #1 tx_data_valid = 1'b0;
  endtask

  // Samples one whole frame, four clocks per bit, starting at the next negedge.
  task automatic expect_frame(input string tag, input logic [7:0] d, input int nb,
                              input bit has_par, input logic par_bit, input int stops);
    logic       line_bits [0:11];
    int         n;
    logic [3:0] vec;
    logic       busy_all;
    line_bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      line_bits[n] = d[i];
      n++;
    end
    if (has_par) begin
      line_bits[n] = par_bit;
      n++;
    end
    for (int i = 0; i < stops; i++) begin
      line_bits[n] = 1'b1;
      n++;
    end
    busy_all = 1'b1;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        vec[c]   = tx_pin;
        busy_all = busy_all & tx_busy;
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(vec), 32'({4{line_bits[b]}}));
    end
    check({tag, "_busy"}, 32'(busy_all), 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_pin"},  32'(tx_pin),  32'd1);
    check({tag, "_busy"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         waited;
    int         t;
    logic [3:0] vec;
    logic       lvl_ok;
    logic       busy_all;

    rst_n         = 1'b0;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    tx_break      = 1'b0;

    #12;
    check("rst_pin",   32'(tx_pin),     32'd1);
    check("rst_busy",  32'(tx_busy),    32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(tx_data_ready), 32'd1);

    // 8N1, 0x55: latency E0+2, alternating data, 40-clock frame
    push(8'h55, waited);
    @(negedge clk);
    check("lat_e0_pin", 32'(tx_pin), 32'd1);
    @(negedge clk);
    check("lat_e1_pin",  32'(tx_pin),  32'd1);
    check("lat_e1_busy", 32'(tx_busy), 32'd0);
    expect_frame("f55", 8'h55, 8, 1'b0, 1'b0, 1);
    expect_idle("f55_idle");

    // 7E2 then 7O1 of 0x35, followed by a five-byte 8N1 burst, all back-to-back
    cfg_data_bits = 4'd7;
    cfg_parity    = 2'b10;
    cfg_stop2     = 1'b1;
    push(8'h35, waited);
    @(negedge clk);
    @(negedge clk);
    check("lat_7e2_pin", 32'(tx_pin), 32'd1);
    fork
      begin
        expect_frame("f7e2", 8'h35, 7, 1'b1, 1'b0, 2);
        expect_frame("f7o1", 8'h35, 7, 1'b1, 1'b1, 1);
        for (int k = 1; k <= 5; k++)
          expect_frame($sformatf("burst%0d", k), 8'(k), 8, 1'b0, 1'b0, 1);
      end
      begin
        repeat (10) @(negedge clk);
        cfg_data_bits = 4'd7;
        cfg_parity    = 2'b01;
        cfg_stop2     = 1'b0;
        push(8'h35, waited);
        t = 0;
        while (fifo_level != 3'd0 && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (t >= 200) check("pop_timeout", 32'(fifo_level), 32'd0);
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        for (int k = 1; k <= 4; k++) push(8'(k), waited);
        @(negedge clk);
        check("burst_full_ready", 32'(tx_data_ready), 32'd0);
        check("burst_full_level", 32'(fifo_level),    32'd4);
        push(8'h05, waited);
        check("burst5_waited", 32'(waited > 0), 32'd1);
        check("burst5_level",  32'(fifo_level), 32'd4);
      end
    join
    expect_idle("burst_idle");

    // Break raised mid-frame of 0xFF; a byte queued during break must wait
    push(8'hFF, waited);
    @(negedge clk);
    @(negedge clk);
    fork
      expect_frame("fff", 8'hFF, 8, 1'b0, 1'b0, 1);
      begin
        repeat (15) @(negedge clk);
        tx_break = 1'b1;
      end
    join
    busy_all = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec[c]   = tx_pin;
      busy_all = busy_all & tx_busy;
    end
    check("brk_low_a",  32'(vec[2:0]), 32'd0);
    check("brk_busy_a", 32'(busy_all), 32'd1);
    push(8'h81, waited);
    check("brk_queued_level", 32'(fifo_level), 32'd1);
    lvl_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vec[c] = tx_pin;
      lvl_ok = lvl_ok & (fifo_level == 3'd1);
    end
    tx_break = 1'b0;
    check("brk_low_b",    32'(vec),    32'd0);
    check("brk_no_pop_a", 32'(lvl_ok), 32'd1);
    @(negedge clk);
    check("brk_last_low", 32'(tx_pin), 32'd0);
    busy_all = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vec[c]   = tx_pin;
      busy_all = busy_all & tx_busy;
      lvl_ok   = lvl_ok & (fifo_level == 3'd1);
    end
    check("brk_release_high", 32'(vec),      32'hF);
    check("brk_release_busy", 32'(busy_all), 32'd1);
    check("brk_no_pop_b",     32'(lvl_ok),   32'd1);
    expect_idle("brk_idle");
    expect_frame("f81", 8'h81, 8, 1'b0, 1'b0, 1);
    expect_idle("f81_idle");

    // Async reset during data bit 3 of 0xA5 with two bytes queued
    push(8'hA5, waited);
    push(8'h11, waited);
    check("pushpop_level", 32'(fifo_level), 32'd1);
    push(8'h22, waited);
    check("queued_level", 32'(fifo_level), 32'd2);
    repeat (18) @(negedge clk);
    check("a5_bit3_pin",  32'(tx_pin),  32'd0);
    check("a5_bit3_busy", 32'(tx_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pin",   32'(tx_pin),        32'd1);
    check("mid_rst_busy",  32'(tx_busy),       32'd0);
    check("mid_rst_level", 32'(fifo_level),    32'd0);
    check("mid_rst_ready", 32'(tx_data_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h3C, waited);
    @(negedge clk);
    @(negedge clk);
    check("lat_3c_pin", 32'(tx_pin), 32'd1);
    expect_frame("f3c", 8'h3C, 8, 1'b0, 1'b0, 1);
    expect_idle("f3c_idle");
    check("f3c_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
